axil_regbank: RTL and testbench
===============================

Name: axil_regbank

Overview:
Parametrised AXI4-Lite slave register bank. It is the successor to the fixed single-register axil_reg_wrapper. It adds:
- N registers
- byte strobes
- independent AW/W acceptance
- read-only status registers fed from fabric
- SLVERR decoding
- per-register access strobes

It sits between the PS AXI-Lite interconnect and the quadruped control/camera fabric as the CSR block.

Parameters:
C_DATA_W, 32, data width in bits; 32 or 64.
C_ADDR_W, 32, AXI address width.
C_NUM_REGS, 16, number of registers; 1..256.
C_RO_MASK, 0, C_NUM_REGS-bit mask; bit i=1 makes reg i read-only, sourced from reg_in.
C_RST_VAL, 0, reset value of every RW register.

Ports:
s_axi_aclk  in  1  clock
s_axi_areset  in  1  synchronous, active-high reset
s_axi_awaddr  in  C_ADDR_W  write address
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  C_DATA_W  write data
s_axi_wstrb  in  C_DATA_W/8  byte strobes
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  C_ADDR_W  read address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  C_DATA_W  read data
s_axi_rresp  out  2  read response
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
reg_out  out  C_NUM_REGS*C_DATA_W  flat register contents; reg i at [i*C_DATA_W +: C_DATA_W]
reg_in  in  C_NUM_REGS*C_DATA_W  status inputs; only RO slices are used
wr_pulse  out  C_NUM_REGS  one-cycle strobe per register on a successful write
rd_pulse  out  C_NUM_REGS  one-cycle strobe per register on an accepted read

Behaviour:
- Reset: one clock and one reset; s_axi_areset is synchronous and active-high.
  - Values at reset: awready=1, wready=1, arready=1, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, wr_pulse=0, rd_pulse=0.
  - All RW registers take C_RST_VAL; held AW/W beats are discarded.
  - Reset mid-transaction drops pending B/R without completing them.
- Decode:
  - LSB = clog2(C_DATA_W/8); idx = addr[LSB +: clog2(C_NUM_REGS)]; low LSB bits are ignored.
  - Address is in range iff addr < C_NUM_REGS*(C_DATA_W/8).
- Write channel:
  - AW and W are each captured in a one-entry holding buffer. awready = !aw_held; wready = !w_held. Either beat may arrive first or both in the same cycle.
  - Commit happens on the edge where aw_held && w_held && !bvalid. On commit, both buffers clear and bvalid=1 on the next cycle.
  - A new AW/W beat may therefore be accepted in the cycle after commit while B is still pending. The next commit waits for B to be consumed (bvalid && bready).
  - In range, RW register: byte k is updated iff wstrb[k]; bresp=OKAY (2'b00); wr_pulse[idx]=1 for exactly the commit cycle+1.
  - RO register or out of range: no state change, bresp=SLVERR (2'b10), no wr_pulse.
  - bvalid and bresp are held stable until bready.
- Read channel:
  - arready = !rvalid. On the AR handshake edge, rdata and rresp are registered and rvalid=1 on the next cycle (latency 1).
  - rvalid, rdata and rresp are held until rready; arready drops meanwhile, so at most one read is outstanding.
  - Read data: RW register returns its stored value; RO register returns the reg_in slice sampled on the handshake edge; out of range returns 0 with SLVERR.
  - rd_pulse[idx]=1 for one cycle after the handshake, for in-range reads only.
- Simultaneous events:
  - A read handshake and a write commit to the same register on the same edge: the read returns the pre-write value.
  - Reads and writes progress independently; there is no priority stall between them.
  - wstrb=0 to an in-range RW register completes OKAY and pulses wr_pulse with no data change.
- reg_out reflects register state continuously; RO slices of reg_out are 0.

Decomposition:
- Package axil_pkg:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - axi_resp_t (2-bit typedef)
  - helper function for addr_lsb(C_DATA_W)
- Sub-module axil_hold_buf: a one-entry valid/ready holding register, parametrised width, with a clear input. It is instantiated twice: AW (address) and W (data+strobe).

Test Plan:
1. Reset, then write 0xDEADBEEF with wstrb=0xF to 0x0C, then read 0x0C -> bresp=OKAY, rdata=0xDEADBEEF, rresp=OKAY, wr_pulse[3] one cycle, reg_out slice 3 = 0xDEADBEEF.
2. W beat presented 3 cycles before AW for addr 0x04 data 0x12345678 wstrb=0x5 over initial 0 -> reg1=0x00340078; bvalid only after AW accepted; wready low while W held.
3. C_RO_MASK bit2 set, reg_in slice 2=0xCAFEF00D: read 0x08 -> 0xCAFEF00D/OKAY with rd_pulse[2]; write 0x08 -> SLVERR, value unchanged.
4. Read 0x40 (out of range, 16 regs) -> rdata=0, SLVERR; write 0x40 -> SLVERR, no wr_pulse, all regs unchanged.
5. Hold bready=0 for 5 cycles after a write -> bvalid/bresp stable. A second AW+W is accepted but not committed until bready; then second bvalid follows. Hold rready=0 for 5 cycles -> arready=0, rdata stable.
6. Write 0x11111111 to 0x00 then start a read of 0x00 in the same cycle as a write commit of 0x22222222 -> read returns 0x11111111; a subsequent read returns 0x22222222. Assert reset while bvalid=1 -> bvalid=0 next cycle and reg0=C_RST_VAL.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite types and helpers for the CSR register bank.
// Response codes and the byte-lane address offset live here.
package axil_pkg;

    typedef logic [1:0] axi_resp_t;

    localparam axi_resp_t RESP_OKAY   = 2'b00;
    localparam axi_resp_t RESP_SLVERR = 2'b10;

    function automatic int addr_lsb(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/axil_hold_buf.sv
// One-entry valid/ready holding register.
// Ready while empty; the consumer empties it with clr.
module axil_hold_buf #(
    parameter int C_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [C_WIDTH-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [C_WIDTH-1:0] out_data,
    output logic               out_valid,
    input  logic               clr
);

    logic take;

    assign in_ready = !out_valid;
    assign take     = in_valid && !out_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (clr) begin
            out_valid <= 1'b0;
        end else if (take) begin
            out_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            out_data <= in_data;
        end
    end

endmodule

// File: rtl/axil_regbank.sv
// AXI4-Lite CSR bank: N registers, byte strobes, RO status slots,
// SLVERR decode and per-register access pulses.
module axil_regbank
    import axil_pkg::*;
#(
    parameter int                        C_DATA_W   = 32,
    parameter int                        C_ADDR_W   = 32,
    parameter int                        C_NUM_REGS = 16,
    parameter logic [C_NUM_REGS-1:0]     C_RO_MASK  = '0,
    parameter logic [C_DATA_W-1:0]       C_RST_VAL  = '0
) (
    input  logic                           s_axi_aclk,
    input  logic                           s_axi_areset,
    input  logic [C_ADDR_W-1:0]            s_axi_awaddr,
    input  logic                           s_axi_awvalid,
    output logic                           s_axi_awready,
    input  logic [C_DATA_W-1:0]            s_axi_wdata,
    input  logic [C_DATA_W/8-1:0]          s_axi_wstrb,
    input  logic                           s_axi_wvalid,
    output logic                           s_axi_wready,
    output logic [1:0]                     s_axi_bresp,
    output logic                           s_axi_bvalid,
    input  logic                           s_axi_bready,
    input  logic [C_ADDR_W-1:0]            s_axi_araddr,
    input  logic                           s_axi_arvalid,
    output logic                           s_axi_arready,
    output logic [C_DATA_W-1:0]            s_axi_rdata,
    output logic [1:0]                     s_axi_rresp,
    output logic                           s_axi_rvalid,
    input  logic                           s_axi_rready,
    output logic [C_NUM_REGS*C_DATA_W-1:0] reg_out,
    input  logic [C_NUM_REGS*C_DATA_W-1:0] reg_in,
    output logic [C_NUM_REGS-1:0]          wr_pulse,
    output logic [C_NUM_REGS-1:0]          rd_pulse
);

    localparam int STRB_W = C_DATA_W / 8;
    localparam int LSB    = addr_lsb(C_DATA_W);
    localparam int IDX_W  = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;
    localparam logic [C_ADDR_W:0] LIMIT =
        (C_ADDR_W+1)'(C_NUM_REGS * STRB_W);

    logic [C_DATA_W-1:0] regs [C_NUM_REGS];
    logic [C_DATA_W-1:0] stat [C_NUM_REGS];

    logic                aw_held;
    logic                w_held;
    logic [C_ADDR_W-1:0] aw_addr;
    logic [C_DATA_W-1:0] w_data;
    logic [STRB_W-1:0]   w_strb;
    logic                commit;

    assign commit = aw_held && w_held && !s_axi_bvalid;

    axil_hold_buf #(.C_WIDTH(C_ADDR_W)) u_aw_buf (
        .clk       (s_axi_aclk),
        .rst       (s_axi_areset),
        .in_data   (s_axi_awaddr),
        .in_valid  (s_axi_awvalid),
        .in_ready  (s_axi_awready),
        .out_data  (aw_addr),
        .out_valid (aw_held),
        .clr       (commit)
    );

    axil_hold_buf #(.C_WIDTH(C_DATA_W + STRB_W)) u_w_buf (
        .clk       (s_axi_aclk),
        .rst       (s_axi_areset),
        .in_data   ({s_axi_wstrb, s_axi_wdata}),
        .in_valid  (s_axi_wvalid),
        .in_ready  (s_axi_wready),
        .out_data  ({w_strb, w_data}),
        .out_valid (w_held),
        .clr       (commit)
    );

    logic [IDX_W-1:0] aw_idx;
    logic             aw_in;
    logic             wr_ok;

    assign aw_idx = aw_addr[LSB +: IDX_W];
    assign aw_in  = {1'b0, aw_addr} < LIMIT;
    assign wr_ok  = aw_in && !C_RO_MASK[aw_idx];

    always_ff @(posedge s_axi_aclk) begin
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (s_axi_areset) begin
                regs[i] <= C_RO_MASK[i] ? '0 : C_RST_VAL;
            end else if (commit && wr_ok && aw_idx == IDX_W'(i)) begin
                for (int k = 0; k < STRB_W; k++) begin
                    if (w_strb[k]) begin
                        regs[i][k*8 +: 8] <= w_data[k*8 +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < C_NUM_REGS; i++) begin
            stat[i] = reg_in[i*C_DATA_W +: C_DATA_W];
            reg_out[i*C_DATA_W +: C_DATA_W] = C_RO_MASK[i] ? '0 : regs[i];
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
            wr_pulse     <= '0;
        end else begin
            wr_pulse <= '0;
            if (commit) begin
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                if (wr_ok) begin
                    wr_pulse <= C_NUM_REGS'(1) << aw_idx;
                end
            end else if (s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end
        end
    end

    logic [IDX_W-1:0]    ar_idx;
    logic                ar_in;
    logic                ar_hs;
    logic [C_DATA_W-1:0] rd_val;

    assign ar_idx        = s_axi_araddr[LSB +: IDX_W];
    assign ar_in         = {1'b0, s_axi_araddr} < LIMIT;
    assign s_axi_arready = !s_axi_rvalid;
    assign ar_hs         = s_axi_arvalid && s_axi_arready;

    // Status slots are sampled live from the fabric on the AR edge.
    always_comb begin
        rd_val = '0;
        if (ar_in) begin
            rd_val = C_RO_MASK[ar_idx] ? stat[ar_idx] : regs[ar_idx];
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= RESP_OKAY;
            rd_pulse     <= '0;
        end else begin
            rd_pulse <= '0;
            if (ar_hs) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_val;
                s_axi_rresp  <= ar_in ? RESP_OKAY : RESP_SLVERR;
                if (ar_in) begin
                    rd_pulse <= C_NUM_REGS'(1) << ar_idx;
                end
            end else if (s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axil_regbank.sv
// Self-checking bench for axil_regbank: directed scenarios plus
// randomized traffic scored against an array model of the bank.
module tb_axil_regbank;

    localparam int NR = 16;
    localparam logic [15:0] RO = 16'h0004;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   awaddr = '0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [31:0]   wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready = 1'b1;
    logic [31:0]   araddr = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready = 1'b1;
    logic [511:0]  reg_out;
    logic [511:0]  reg_in = '0;
    logic [15:0]   wr_pulse;
    logic [15:0]   rd_pulse;

    int errors = 0;
    int checks = 0;

    logic [31:0] model [NR];

    always #5 clk = ~clk;

    axil_regbank #(
        .C_DATA_W   (32),
        .C_ADDR_W   (32),
        .C_NUM_REGS (NR),
        .C_RO_MASK  (RO),
        .C_RST_VAL  (32'h0)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_areset  (rst),
        .s_axi_awaddr  (awaddr),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .reg_out       (reg_out),
        .reg_in        (reg_in),
        .wr_pulse      (wr_pulse),
        .rd_pulse      (rd_pulse)
    );

    function automatic logic [31:0] slice(input int i);
        return reg_out[i*32 +: 32];
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++)
            if (s[k]) r[k*8 +: 8] = d[k*8 +: 8];
        return r;
    endfunction

    function automatic bit in_rng(input logic [31:0] a);
        return a < 32'd64;
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'(a[5:2]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp,
                             output logic [15:0] wp, output logic [15:0] wp_after);
        int n = 0;
        bit ad = 0;
        bit wd = 0;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        while (!(ad && wd) && n < 50) begin
            if (awvalid && awready) ad = 1;
            if (wvalid && wready) wd = 1;
            tick(); n++;
            if (ad) awvalid = 1'b0;
            if (wd) wvalid = 1'b0;
        end
        while (!bvalid && n < 50) begin
            tick(); n++;
        end
        resp = bresp; wp = wr_pulse;
        if (!bvalid) begin
            errors++; checks++;
            $display("FAIL write_timeout addr=%h bvalid=%b required 1", a, bvalid);
        end
        tick();
        wp_after = wr_pulse;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                            output logic [1:0] resp, output logic [15:0] rp);
        int n = 0;
        bit done = 0;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        while (!done && n < 50) begin
            if (arready) done = 1;
            tick(); n++;
        end
        arvalid = 1'b0;
        while (!rvalid && n < 50) begin
            tick(); n++;
        end
        d = rdata; resp = rresp; rp = rd_pulse;
        if (!rvalid) begin
            errors++; checks++;
            $display("FAIL read_timeout addr=%h rvalid=%b required 1", a, rvalid);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = 32'h0;
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_ready got=%b required 111", {awready, wready, arready});
        end
        checks++;
        if ({bvalid, rvalid, bresp, rresp} !== 6'b0) begin
            errors++;
            $display("FAIL reset_resp got=%b required 0", {bvalid, rvalid, bresp, rresp});
        end
        checks++;
        if (rdata !== 32'h0 || wr_pulse !== 16'h0 || rd_pulse !== 16'h0) begin
            errors++;
            $display("FAIL reset_data rdata=%h wp=%h rp=%h required 0", rdata, wr_pulse, rd_pulse);
        end
        checks++;
        if (reg_out !== 512'h0) begin
            errors++;
            $display("FAIL reset_regout got nonzero required 0");
        end
    endtask

    task automatic test_basic();
        logic [1:0] r;
        logic [15:0] p, pa;
        logic [31:0] d;
        axi_write(32'h0C, 32'hDEADBEEF, 4'hF, r, p, pa);
        model[3] = 32'hDEADBEEF;
        checks++;
        if (r !== 2'b00) begin
            errors++; $display("FAIL basic_bresp got=%b required 00", r);
        end
        checks++;
        if (p !== 16'h0008 || pa !== 16'h0) begin
            errors++; $display("FAIL basic_wr_pulse got=%h then %h required 0008 then 0000", p, pa);
        end
        checks++;
        if (slice(3) !== 32'hDEADBEEF) begin
            errors++; $display("FAIL basic_regout got=%h required deadbeef", slice(3));
        end
        axi_read(32'h0C, d, r, p);
        checks++;
        if (d !== 32'hDEADBEEF || r !== 2'b00) begin
            errors++; $display("FAIL basic_read got=%h/%b required deadbeef/00", d, r);
        end
        checks++;
        if (p !== 16'h0008) begin
            errors++; $display("FAIL basic_rd_pulse got=%h required 0008", p);
        end
    endtask

    task automatic test_w_before_aw();
        int n = 0;
        wdata = 32'h12345678; wstrb = 4'h5; wvalid = 1'b1; bready = 1'b1;
        tick();
        wvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (wready !== 1'b0 || bvalid !== 1'b0) begin
                errors++;
                $display("FAIL wfirst_hold cyc=%0d wready=%b bvalid=%b required 0/0", c, wready, bvalid);
            end
            tick();
        end
        awaddr = 32'h04; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        checks++;
        if (bvalid !== 1'b0) begin
            errors++; $display("FAIL wfirst_early_b got=%b required 0", bvalid);
        end
        while (!bvalid && n < 20) begin
            tick(); n++;
        end
        model[1] = merge(32'h0, 32'h12345678, 4'h5);
        checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            errors++; $display("FAIL wfirst_b got=%b/%b required 1/00", bvalid, bresp);
        end
        checks++;
        if (slice(1) !== model[1]) begin
            errors++; $display("FAIL wfirst_data got=%h required %h", slice(1), model[1]);
        end
        tick();
    endtask

    task automatic test_ro();
        logic [1:0] r;
        logic [15:0] p, pa;
        logic [31:0] d;
        reg_in[95:64] = 32'hCAFEF00D;
        axi_read(32'h08, d, r, p);
        checks++;
        if (d !== 32'hCAFEF00D || r !== 2'b00 || p !== 16'h0004) begin
            errors++;
            $display("FAIL ro_read got=%h/%b/%h required cafef00d/00/0004", d, r, p);
        end
        axi_write(32'h08, 32'h55555555, 4'hF, r, p, pa);
        checks++;
        if (r !== 2'b10 || p !== 16'h0) begin
            errors++; $display("FAIL ro_write got=%b/%h required 10/0000", r, p);
        end
        checks++;
        if (slice(2) !== 32'h0) begin
            errors++; $display("FAIL ro_regout got=%h required 0", slice(2));
        end
        axi_read(32'h08, d, r, p);
        checks++;
        if (d !== 32'hCAFEF00D) begin
            errors++; $display("FAIL ro_after got=%h required cafef00d", d);
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0] r;
        logic [15:0] p, pa;
        logic [31:0] d;
        bit bad = 0;
        axi_read(32'h40, d, r, p);
        checks++;
        if (d !== 32'h0 || r !== 2'b10 || p !== 16'h0) begin
            errors++; $display("FAIL oor_read got=%h/%b/%h required 0/10/0", d, r, p);
        end
        axi_write(32'h40, 32'hFFFFFFFF, 4'hF, r, p, pa);
        checks++;
        if (r !== 2'b10 || p !== 16'h0) begin
            errors++; $display("FAIL oor_write got=%b/%h required 10/0000", r, p);
        end
        for (int i = 0; i < NR; i++)
            if (slice(i) !== (RO[i] ? 32'h0 : model[i])) bad = 1;
        checks++;
        if (bad) begin
            errors++; $display("FAIL oor_regs got=changed required unchanged");
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        bit bad = 0;
        bready = 1'b0;
        awaddr = 32'h10; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        while (!bvalid && n < 20) begin
            tick(); n++;
        end
        model[4] = 32'hA5A5A5A5;
        awaddr = 32'h14; wdata = 32'h5A5A5A5A;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0
                || wready !== 1'b0 || slice(5) !== model[5]) bad = 1;
            tick();
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL b2b_stall bvalid=%b bresp=%b reg5=%h required 1/00/%h", bvalid, bresp, slice(5), model[5]);
        end
        checks++;
        if (slice(4) !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL b2b_first got=%h required a5a5a5a5", slice(4));
        end
        bready = 1'b1;
        n = 0;
        while (bvalid && n < 20) begin
            tick(); n++;
        end
        while (!bvalid && n < 20) begin
            tick(); n++;
        end
        model[5] = 32'h5A5A5A5A;
        checks++;
        if (bvalid !== 1'b1 || slice(5) !== 32'h5A5A5A5A) begin
            errors++; $display("FAIL b2b_second bvalid=%b reg5=%h required 1/5a5a5a5a", bvalid, slice(5));
        end
        tick();
        rready = 1'b0;
        araddr = 32'h10; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            if (rvalid !== 1'b1 || arready !== 1'b0 || rdata !== 32'hA5A5A5A5) bad = 1;
            tick();
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL r_stall rvalid=%b arready=%b rdata=%h required 1/0/a5a5a5a5", rvalid, arready, rdata);
        end
        rready = 1'b1;
        tick();
        checks++;
        if (rvalid !== 1'b0) begin
            errors++; $display("FAIL r_release got=%b required 0", rvalid);
        end
    endtask

    task automatic test_collision();
        logic [1:0] r;
        logic [15:0] p, pa;
        logic [31:0] d;
        int n = 0;
        axi_write(32'h00, 32'h11111111, 4'hF, r, p, pa);
        awaddr = 32'h00; wdata = 32'h22222222; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h00; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        checks++;
        if (rvalid !== 1'b1 || bvalid !== 1'b1 || rdata !== 32'h11111111) begin
            errors++; $display("FAIL collide_read rvalid=%b bvalid=%b rdata=%h required 1/1/11111111", rvalid, bvalid, rdata);
        end
        tick();
        model[0] = 32'h22222222;
        axi_read(32'h00, d, r, p);
        checks++;
        if (d !== 32'h22222222) begin
            errors++; $display("FAIL collide_after got=%h required 22222222", d);
        end
        bready = 1'b0;
        awaddr = 32'h00; wdata = 32'h33333333;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        while (!bvalid && n < 20) begin
            tick(); n++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = 32'h0;
        checks++;
        if (bvalid !== 1'b0 || slice(0) !== 32'h0 || awready !== 1'b1) begin
            errors++; $display("FAIL reset_mid bvalid=%b reg0=%h awready=%b required 0/0/1", bvalid, slice(0), awready);
        end
        bready = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [1:0] r;
        logic [15:0] p, pa;
        logic [31:0] d, a, v, exp_d;
        logic [3:0] s;
        bit ok;
        int i;
        for (int t = 0; t < 80; t++) begin
            reg_in = {16{$urandom()}};
            if ($urandom_range(0, 7) == 0)
                a = 32'h40 + ($urandom_range(0, 63) << 2);
            else
                a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            i = idx_of(a);
            ok = in_rng(a) && !RO[i];
            if ($urandom_range(0, 1) == 0) begin
                v = $urandom();
                s = 4'($urandom_range(0, 15));
                axi_write(a, v, s, r, p, pa);
                if (ok) model[i] = merge(model[i], v, s);
                checks++;
                if (r !== (ok ? 2'b00 : 2'b10) || p !== (ok ? (16'h1 << i) : 16'h0)) begin
                    errors++; $display("FAIL rand_write addr=%h got=%b/%h required ok=%0d", a, r, p, ok);
                end
                checks++;
                if (in_rng(a) && slice(i) !== (RO[i] ? 32'h0 : model[i])) begin
                    errors++; $display("FAIL rand_regout idx=%0d got=%h required %h", i, slice(i), model[i]);
                end
            end else begin
                if (!in_rng(a)) exp_d = 32'h0;
                else if (RO[i]) exp_d = reg_in[i*32 +: 32];
                else exp_d = model[i];
                axi_read(a, d, r, p);
                checks++;
                if (d !== exp_d || r !== (in_rng(a) ? 2'b00 : 2'b10)
                    || p !== (in_rng(a) ? (16'h1 << i) : 16'h0)) begin
                    errors++; $display("FAIL rand_read addr=%h got=%h/%b/%h required %h", a, d, r, p, exp_d);
                end
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_w_before_aw();
        test_ro();
        test_out_of_range();
        test_back_to_back();
        test_collision();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
